// File: rtl/trojan_pkg.sv
// -----------------------------------------------------------------------------
// trojan_pkg
// Constants and types shared by the 2-bit-per-cycle key-leak transmitter and
// its receive-side companion (trojan_leak_rx_256).
//   TRIG_WORD  : value on data[31:0] that arms a frame
//   KEY_W      : key width (BEAT_W * LOAD_BEATS)
//   BEAT_W     : data-bus width, one key beat per cycle
//   SYM_W      : leaked bits per cycle
//   LOAD_BEATS : bus beats loaded after the trigger
//   N_SYM      : symbols per frame (KEY_W / SYM_W)
// -----------------------------------------------------------------------------
package trojan_pkg;

  localparam logic [31:0] TRIG_WORD  = 32'h0044ab93;
  localparam int          BEAT_W     = 64;
  localparam int          LOAD_BEATS = 4;
  localparam int          KEY_W      = BEAT_W * LOAD_BEATS;
  localparam int          SYM_W      = 2;
  localparam int          N_SYM      = KEY_W / SYM_W;

  // Derived counter widths
  localparam int          BEAT_IDX_W = $clog2(LOAD_BEATS);
  localparam int          SYM_IDX_W  = $clog2(N_SYM);
  localparam int          SYM_CNT_W  = $clog2(SYM_W + 1);
  localparam int          ERR_W      = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/leak_sym_cmp.sv
// -----------------------------------------------------------------------------
// leak_sym_cmp
// Combinational bit-difference count between one leaked symbol and the
// matching slice of the snooped key.
//   sym_a  in  SYM_W      leaked symbol
//   sym_b  in  SYM_W      expected symbol
//   diff   out SYM_CNT_W  popcount(sym_a ^ sym_b), 0..SYM_W
// -----------------------------------------------------------------------------
module leak_sym_cmp
  import trojan_pkg::*;
#(
  parameter int P_SYM_W = SYM_W,
  parameter int P_CNT_W = $clog2(P_SYM_W + 1)
) (
  input  logic [P_SYM_W-1:0] sym_a,
  input  logic [P_SYM_W-1:0] sym_b,
  output logic [P_CNT_W-1:0] diff
);

  logic [P_SYM_W-1:0] x;

  always_comb begin
    x    = sym_a ^ sym_b;
    diff = '0;
    for (int i = 0; i < P_SYM_W; i++) begin
      diff = diff + P_CNT_W'(x[i]);
    end
  end

endmodule

// File: rtl/trojan_leak_rx_256.sv
// -----------------------------------------------------------------------------
// trojan_leak_rx_256
// Receive-side companion of the 2-bit-per-cycle key-leak trojan. Snoops the
// data bus for TRIG_WORD, records the four following beats as the expected
// key, then reassembles the key from 128 leaked 2-bit symbols (LSBs first)
// while counting bit errors against the snooped copy.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_all_n  in   1      synchronous active-low reset
//   data       in   64     snooped data bus
//   leak_sym   in   2      leaked symbol, LSBs of the key first
//   clr        in   1      acknowledge, DONE -> IDLE (wins over a trigger)
//   busy       out  1      high in LOAD and CAPTURE
//   key_valid  out  1      high in DONE
//   key_out    out  256    reassembled key
//   exp_key    out  256    key as snooped during LOAD
//   err_cnt    out  9      differing bits, leaked vs snooped (0..256)
//   match      out  1      key_valid && err_cnt == 0
//   state_dbg  out  2      current FSM state, for checkers
//
// Handshake: there is no backpressure. A frame starts on the cycle where
// data[31:0]==TRIG_WORD is sampled in IDLE or DONE; key_valid rises 133 cycles
// later and stays high until clr, a re-arming trigger, or reset.
// -----------------------------------------------------------------------------
module trojan_leak_rx_256
  import trojan_pkg::*;
(
  input  logic              clk,
  input  logic              rst_all_n,
  input  logic [BEAT_W-1:0] data,
  input  logic [SYM_W-1:0]  leak_sym,
  input  logic              clr,
  output logic              busy,
  output logic              key_valid,
  output logic [KEY_W-1:0]  key_out,
  output logic [KEY_W-1:0]  exp_key,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              match,
  output rx_state_e         state_dbg
);

  // State and datapath registers
  rx_state_e             state_q,     state_d;
  logic [BEAT_IDX_W-1:0] beat_q,      beat_d;
  logic [SYM_IDX_W-1:0]  sym_q,       sym_d;
  logic [KEY_W-1:0]      key_out_q,   key_out_d;
  logic [KEY_W-1:0]      exp_key_q,   exp_key_d;
  logic [ERR_W-1:0]      err_cnt_q,   err_cnt_d;
  logic                  busy_q,      busy_d;
  logic                  key_valid_q, key_valid_d;
  logic                  match_q,     match_d;

  logic                  trig;
  logic [SYM_W-1:0]      exp_sym;
  logic [SYM_CNT_W-1:0]  sym_err;

  assign trig = (data[31:0] == TRIG_WORD);

  // Expected symbol for the current capture slot. exp_key is only written in
  // LOAD, so this slice is stable for the whole CAPTURE phase.
  assign exp_sym = exp_key_q[sym_q*SYM_W +: SYM_W];

  leak_sym_cmp #(
    .P_SYM_W (SYM_W),
    .P_CNT_W (SYM_CNT_W)
  ) u_cmp (
    .sym_a (leak_sym),
    .sym_b (exp_sym),
    .diff  (sym_err)
  );

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    sym_d     = sym_q;
    key_out_d = key_out_q;
    exp_key_d = exp_key_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d   = LOAD;
          beat_d    = '0;
          sym_d     = '0;
          err_cnt_d = '0;
        end
      end

      // Triggers here are ordinary key data.
      LOAD: begin
        exp_key_d[beat_q*BEAT_W +: BEAT_W] = data;
        beat_d = beat_q + 1'b1;
        if (beat_q == BEAT_IDX_W'(LOAD_BEATS - 1)) begin
          state_d = CAPTURE;
        end
      end

      // Shift in from the top so the first symbol ends up in key_out[1:0]
      // after N_SYM shifts. err_cnt tops out at exactly KEY_W, which fits.
      CAPTURE: begin
        key_out_d = {leak_sym, key_out_q[KEY_W-1:SYM_W]};
        err_cnt_d = err_cnt_q + ERR_W'(sym_err);
        sym_d     = sym_q + 1'b1;
        if (sym_q == SYM_IDX_W'(N_SYM - 1)) begin
          state_d = DONE;
        end
      end

      // clr takes priority over a simultaneous trigger.
      DONE: begin
        if (clr) begin
          state_d   = IDLE;
          beat_d    = '0;
          sym_d     = '0;
          err_cnt_d = '0;
        end else if (trig) begin
          state_d   = LOAD;
          beat_d    = '0;
          sym_d     = '0;
          err_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered decodes of the next state.
    busy_d      = (state_d == LOAD) || (state_d == CAPTURE);
    key_valid_d = (state_d == DONE);
    match_d     = (state_d == DONE) && (err_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_all_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      sym_q       <= '0;
      key_out_q   <= '0;
      exp_key_q   <= '0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      sym_q       <= sym_d;
      key_out_q   <= key_out_d;
      exp_key_q   <= exp_key_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
      key_valid_q <= key_valid_d;
      match_q     <= match_d;
    end
  end

  assign busy      = busy_q;
  assign key_valid = key_valid_q;
  assign key_out   = key_out_q;
  assign exp_key   = exp_key_q;
  assign err_cnt   = err_cnt_q;
  assign match     = match_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_trojan_leak_rx_256.sv
// -----------------------------------------------------------------------------
// tb_trojan_leak_rx_256
// Self-checking bench for trojan_leak_rx_256. The driver pushes the expected
// result of each frame (snooped key, leaked key, bit-error count, trigger
// cycle) into queues; a monitor pops and compares on every rising key_valid.
// -----------------------------------------------------------------------------
module tb_trojan_leak_rx_256;
  import trojan_pkg::*;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_all_n;
  logic [BEAT_W-1:0] data;
  logic [SYM_W-1:0]  leak_sym;
  logic              clr;
  logic              busy;
  logic              key_valid;
  logic [KEY_W-1:0]  key_out;
  logic [KEY_W-1:0]  exp_key;
  logic [ERR_W-1:0]  err_cnt;
  logic              match;
  rx_state_e         state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  trojan_leak_rx_256 dut (
    .clk       (clk),
    .rst_all_n (rst_all_n),
    .data      (data),
    .leak_sym  (leak_sym),
    .clr       (clr),
    .busy      (busy),
    .key_valid (key_valid),
    .key_out   (key_out),
    .exp_key   (exp_key),
    .err_cnt   (err_cnt),
    .match     (match),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [KEY_W-1:0] exp_snoop_q[$];
  logic [KEY_W-1:0] exp_out_q[$];
  logic [ERR_W-1:0] exp_err_q[$];
  int               exp_cyc_q[$];

  task automatic check(input string name, input logic [KEY_W-1:0] act,
                       input logic [KEY_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one pop per rising edge of key_valid.
  logic valid_seen = 1'b0;
  always @(negedge clk) begin
    if (key_valid === 1'b1 && !valid_seen) begin
      if (exp_out_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid act=1 exp=0 (cycle %0d)", cyc);
      end else begin
        logic [KEY_W-1:0] e_snoop, e_out;
        logic [ERR_W-1:0] e_err;
        int               e_cyc;
        e_snoop = exp_snoop_q.pop_front();
        e_out   = exp_out_q.pop_front();
        e_err   = exp_err_q.pop_front();
        e_cyc   = exp_cyc_q.pop_front();
        check("key_out",  key_out, e_out);
        check("exp_key",  exp_key, e_snoop);
        check("err_cnt",  KEY_W'(err_cnt), KEY_W'(e_err));
        check("match",    KEY_W'(match), KEY_W'(e_err == 0));
        check("latency",  KEY_W'(cyc - e_cyc), KEY_W'(133));
      end
    end
    valid_seen = (key_valid === 1'b1);
  end

  // ---------------- driver ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Random bus word that is never a trigger.
  function automatic logic [BEAT_W-1:0] rnd_safe();
    logic [BEAT_W-1:0] v;
    v = {$urandom(), $urandom()};
    if (v[31:0] == TRIG_WORD) v[0] = ~v[0];
    return v;
  endfunction

  function automatic logic [KEY_W-1:0] rnd_flips(input int n);
    logic [KEY_W-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[$urandom_range(KEY_W-1, 0)] = 1'b1;
    return m;
  endfunction

  task automatic check_idle_outputs(input string tag, input bit zero_data);
    check({tag, "_state"},     KEY_W'(state_dbg), KEY_W'(IDLE));
    check({tag, "_busy"},      KEY_W'(busy),      '0);
    check({tag, "_key_valid"}, KEY_W'(key_valid), '0);
    check({tag, "_match"},     KEY_W'(match),     '0);
    if (zero_data) begin
      check({tag, "_key_out"}, key_out,           '0);
      check({tag, "_exp_key"}, exp_key,           '0);
      check({tag, "_err_cnt"}, KEY_W'(err_cnt),   '0);
    end
  endtask

  // One frame: trigger, four beats, 128 symbols of (key ^ flip).
  // spur_cap puts the trigger word on the bus during CAPTURE; abort_at >= 0
  // pulses reset at that symbol instead of finishing the frame.
  task automatic send_frame(input logic [BEAT_W-1:0] b0, b1, b2, b3,
                            input logic [KEY_W-1:0] flip,
                            input bit spur_cap, input bit end_clr,
                            input int abort_at);
    logic [KEY_W-1:0] key, leaked;
    int n_sym;
    key    = {b3, b2, b1, b0};
    leaked = key ^ flip;
    n_sym  = (abort_at >= 0) ? abort_at : N_SYM;
    if (abort_at < 0) begin
      exp_snoop_q.push_back(key);
      exp_out_q.push_back(leaked);
      exp_err_q.push_back(ERR_W'($countones(flip)));
      exp_cyc_q.push_back(cyc);
    end
    data     = {$urandom(), TRIG_WORD};
    leak_sym = SYM_W'($urandom_range(3, 0));
    tick;
    check("armed_state",     KEY_W'(state_dbg), KEY_W'(LOAD));
    check("armed_busy",      KEY_W'(busy),      KEY_W'(1));
    check("armed_err_clear", KEY_W'(err_cnt),   '0);
    check("armed_valid",     KEY_W'(key_valid), '0);
    data = b0; tick;
    data = b1; tick;
    data = b2; tick;
    data = b3; tick;
    for (int i = 0; i < n_sym; i++) begin
      leak_sym = leaked[SYM_W*i +: SYM_W];
      data     = (spur_cap && i == 40) ? {32'h5a5a5a5a, TRIG_WORD}
                                       : {$urandom(), $urandom()};
      tick;
    end
    data     = rnd_safe();
    leak_sym = '0;
    if (abort_at >= 0) begin
      rst_all_n = 1'b0;
      tick;
      rst_all_n = 1'b1;
      check_idle_outputs("abort", 1'b1);
    end else begin
      check("done_busy", KEY_W'(busy), '0);
      if (end_clr) begin
        clr = 1'b1;
        tick;
        clr = 1'b0;
        check_idle_outputs("clr", 1'b0);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [BEAT_W-1:0] cb0, cb1, cb2, cb3;
    logic [KEY_W-1:0]  fl;
    int                budget;

    cb0 = 64'h0123456789abcdef;
    cb1 = 64'hfedcba9876543210;
    cb2 = 64'h0f0f0f0f0f0f0f0f;
    cb3 = 64'ha5a5a5a5a5a5a5a5;

    rst_all_n = 1'b0;
    data      = '0;
    leak_sym  = '0;
    clr       = 1'b0;
    tick; tick; tick;
    check_idle_outputs("reset", 1'b1);
    rst_all_n = 1'b1;
    data      = rnd_safe();
    tick;

    // Clean frame
    send_frame(cb0, cb1, cb2, cb3, '0, 1'b0, 1'b1, -1);

    // Corrupted: symbol 0 inverted, bit0 of symbol 127 flipped (bit 254)
    fl = '0;
    fl[0] = 1'b1; fl[1] = 1'b1; fl[254] = 1'b1;
    send_frame(cb0, cb1, cb2, cb3, fl, 1'b0, 1'b1, -1);

    // Spurious triggers in LOAD beat 2 and in CAPTURE
    send_frame(cb0, cb1, {32'h13579bdf, TRIG_WORD}, cb3, '0, 1'b1, 1'b1, -1);

    // Errored frame left in DONE, then re-armed by a bare trigger
    send_frame(rnd_safe(), rnd_safe(), rnd_safe(), rnd_safe(), rnd_flips(5),
               1'b0, 1'b0, -1);
    send_frame(rnd_safe(), rnd_safe(), rnd_safe(), rnd_safe(), rnd_flips(2),
               1'b0, 1'b0, -1);

    // clr and trigger together in DONE: clr wins
    data = {32'h0, TRIG_WORD};
    clr  = 1'b1;
    tick;
    clr  = 1'b0;
    data = rnd_safe();
    check_idle_outputs("clr_trig", 1'b0);
    for (int i = 0; i < 10; i++) tick;
    check("clr_trig_no_frame", KEY_W'(busy), '0);

    // Reset at capture symbol 60, then a full frame
    send_frame(rnd_safe(), rnd_safe(), rnd_safe(), rnd_safe(), '0,
               1'b0, 1'b1, 60);
    send_frame(cb3, cb2, cb1, cb0, '0, 1'b0, 1'b1, -1);

    // All-ones key, all-zero symbols
    send_frame('1, '1, '1, '1, '1, 1'b0, 1'b1, -1);

    // Random frames, idle gaps in between
    for (int f = 0; f < 6; f++) begin
      send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()},
                 {$urandom(), $urandom()}, {$urandom(), $urandom()},
                 rnd_flips($urandom_range(4, 0)), 1'b0, f[0], -1);
      for (int g = $urandom_range(3, 0); g > 0; g--) begin
        data = rnd_safe();
        tick;
      end
    end

    // Drain
    budget = 300;
    while (exp_out_q.size() != 0 && budget > 0) begin
      tick;
      budget--;
    end
    if (exp_out_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain act=%0d exp=0 frames outstanding", exp_out_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
